jstk_dir_filter: RTL



---
 rtl/jstk_pkg.sv | 30 +++
 rtl/jstk_dir_filter_if.sv | 11 +
 rtl/jstk_axis_filter.sv | 116 +++++++++++
 rtl/jstk_dir_filter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/jstk_pkg.sv
// Shared joystick types: per-axis class encoding, dir_state bit indices, raw frame field positions.
// Pure declarations; no latency, no backpressure.
package jstk_pkg;

    typedef enum logic [1:0] {
        CLS_NEUTRAL = 2'd0,
        CLS_POS     = 2'd1,
        CLS_NEG     = 2'd2
    } axis_cls_e;

    localparam int FRAME_W = 40;
    localparam int POS_W   = 10;

    localparam int DIR_UP    = 3;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_RIGHT = 0;

    localparam int X_HI_MSB = 39;
    localparam int X_HI_LSB = 38;
    localparam int X_LO_MSB = 23;
    localparam int X_LO_LSB = 16;
    localparam int Y_HI_MSB = 37;
    localparam int Y_HI_LSB = 36;
    localparam int Y_LO_MSB = 15;
    localparam int Y_LO_LSB = 8;
    localparam int TRIG_BIT = 35;
    localparam int JOY_BIT  = 34;

endpackage

// File: rtl/jstk_dir_filter_if.sv
// Raw PmodJSTK frame bus: one-cycle valid strobe plus 40-bit frame.
// No backpressure: the consumer accepts a frame on every strobe.
interface jstk_dir_filter_if;
    import jstk_pkg::*;

    logic               frame_valid;
    logic [FRAME_W-1:0] frame_data;

    modport master (output frame_valid, frame_data);
    modport slave  (input  frame_valid, frame_data);
endinterface

// File: rtl/jstk_axis_filter.sv
// One joystick axis: hysteresis classifier, frame-count debounce, optional auto-repeat (JSTK_AUTOREPEAT_EN).
// Class and pulses register on the frame's own edge; accepts a frame every cycle, no backpressure.
module jstk_axis_filter
    import jstk_pkg::*;
#(
`ifdef JSTK_AUTOREPEAT_EN
    parameter int REPEAT_DELAY  = 10,
    parameter int REPEAT_PERIOD = 4,
`endif
    parameter int CENTER        = 512,
    parameter int DEAD_ENTER    = 200,
    parameter int DEAD_EXIT     = 150,
    parameter int STABLE_FRAMES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pos_vld,
    input  logic [POS_W-1:0] pos,
    output axis_cls_e        cls,
    output logic             pulse_pos,
    output logic             pulse_neg
);

    localparam int CW = $clog2(STABLE_FRAMES + 1);
    localparam logic [10:0] HI_ENTER = 11'(CENTER + DEAD_ENTER);
    localparam logic [10:0] LO_ENTER = 11'(CENTER - DEAD_ENTER);
    localparam logic [10:0] HI_EXIT  = 11'(CENTER + DEAD_EXIT);
    localparam logic [10:0] LO_EXIT  = 11'(CENTER - DEAD_EXIT);

    axis_cls_e   raw;
    axis_cls_e   cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic        commit;
    logic [10:0] pos_w;

    assign pos_w = {1'b0, pos};

    // Exit thresholds only apply while already committed to that side.
    always_comb begin
        raw = CLS_NEUTRAL;
        if (pos_w > HI_ENTER)
            raw = CLS_POS;
        else if (pos_w < LO_ENTER)
            raw = CLS_NEG;
        else if (cls == CLS_POS && pos_w > HI_EXIT)
            raw = CLS_POS;
        else if (cls == CLS_NEG && pos_w < LO_EXIT)
            raw = CLS_NEG;
    end

    // cnt stays below STABLE_FRAMES because reaching it commits and clears.
    always_comb begin
        cnt_nxt = CW'(1);
        if (raw == cand && cnt != '0)
            cnt_nxt = cnt + CW'(1);
        commit = (raw != cls) && (int'(cnt_nxt) >= STABLE_FRAMES);
    end

`ifdef JSTK_AUTOREPEAT_EN
    logic [15:0] rep_cnt;
    logic [15:0] rep_nxt;
    logic        rep_first;
    logic        rep_fire;

    assign rep_nxt  = rep_cnt + 16'd1;
    assign rep_fire = rep_first ? (rep_nxt == 16'(REPEAT_DELAY)) : (rep_nxt == 16'(REPEAT_PERIOD));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cls       <= CLS_NEUTRAL;
            cand      <= CLS_NEUTRAL;
            cnt       <= '0;
            pulse_pos <= 1'b0;
            pulse_neg <= 1'b0;
`ifdef JSTK_AUTOREPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b0;
`endif
        end else begin
            pulse_pos <= 1'b0;
            pulse_neg <= 1'b0;
            if (pos_vld) begin
                if (raw == cls) begin
                    cnt <= '0;
                end else if (commit) begin
                    cls       <= raw;
                    cnt       <= '0;
                    pulse_pos <= (raw == CLS_POS);
                    pulse_neg <= (raw == CLS_NEG);
                end else begin
                    cand <= raw;
                    cnt  <= cnt_nxt;
                end
`ifdef JSTK_AUTOREPEAT_EN
                // Schedule counts frames since the commit or since the last repeat.
                if (commit) begin
                    rep_cnt   <= '0;
                    rep_first <= 1'b1;
                end else if (cls != CLS_NEUTRAL) begin
                    if (rep_fire) begin
                        rep_cnt   <= '0;
                        rep_first <= 1'b0;
                        pulse_pos <= (cls == CLS_POS);
                        pulse_neg <= (cls == CLS_NEG);
                    end else if (rep_cnt != '1) begin
                        rep_cnt <= rep_nxt;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: rtl/jstk_dir_filter.sv
// PmodJSTK frame -> debounced direction state/pulses and button edge pulses (auto-repeat via JSTK_AUTOREPEAT_EN).
// Positions 1 cycle after the strobe, direction/button outputs 2 cycles; fully pipelined, no backpressure.
module jstk_dir_filter
    import jstk_pkg::*;
#(
`ifdef JSTK_AUTOREPEAT_EN
    parameter int REPEAT_DELAY  = 10,
    parameter int REPEAT_PERIOD = 4,
`endif
    parameter int CENTER        = 512,
    parameter int DEAD_ENTER    = 200,
    parameter int DEAD_EXIT     = 150,
    parameter int STABLE_FRAMES = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    jstk_dir_filter_if.slave         bus,
    output logic [POS_W-1:0]         x_pos,
    output logic [POS_W-1:0]         y_pos,
    output logic [3:0]               dir_state,
    output logic [3:0]               dir_pulse,
    output logic                     btn_trig_pulse,
    output logic                     btn_joy_pulse
);

    logic      frame_q_vld;
    logic      trig_q;
    logic      joy_q;
    logic      trig_prev;
    logic      joy_prev;
    axis_cls_e x_cls;
    axis_cls_e y_cls;
    logic      x_pulse_pos, x_pulse_neg;
    logic      y_pulse_pos, y_pulse_neg;
    logic      unused_frame_bits;

    assign unused_frame_bits = ^{bus.frame_data[33:24], bus.frame_data[7:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_q_vld <= 1'b0;
            x_pos       <= '0;
            y_pos       <= '0;
            trig_q      <= 1'b0;
            joy_q       <= 1'b0;
        end else begin
            frame_q_vld <= bus.frame_valid;
            if (bus.frame_valid) begin
                x_pos  <= {bus.frame_data[X_HI_MSB:X_HI_LSB], bus.frame_data[X_LO_MSB:X_LO_LSB]};
                y_pos  <= {bus.frame_data[Y_HI_MSB:Y_HI_LSB], bus.frame_data[Y_LO_MSB:Y_LO_LSB]};
                trig_q <= bus.frame_data[TRIG_BIT];
                joy_q  <= bus.frame_data[JOY_BIT];
            end
        end
    end

    // Button edges compare consecutive frames, not consecutive clocks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trig_prev      <= 1'b0;
            joy_prev       <= 1'b0;
            btn_trig_pulse <= 1'b0;
            btn_joy_pulse  <= 1'b0;
        end else begin
            btn_trig_pulse <= 1'b0;
            btn_joy_pulse  <= 1'b0;
            if (frame_q_vld) begin
                trig_prev      <= trig_q;
                joy_prev       <= joy_q;
                btn_trig_pulse <= trig_q & ~trig_prev;
                btn_joy_pulse  <= joy_q & ~joy_prev;
            end
        end
    end

    jstk_axis_filter #(
`ifdef JSTK_AUTOREPEAT_EN
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
`endif
        .CENTER        (CENTER),
        .DEAD_ENTER    (DEAD_ENTER),
        .DEAD_EXIT     (DEAD_EXIT),
        .STABLE_FRAMES (STABLE_FRAMES)
    ) u_x_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .pos_vld   (frame_q_vld),
        .pos       (x_pos),
        .cls       (x_cls),
        .pulse_pos (x_pulse_pos),
        .pulse_neg (x_pulse_neg)
    );

    jstk_axis_filter #(
`ifdef JSTK_AUTOREPEAT_EN
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
`endif
        .CENTER        (CENTER),
        .DEAD_ENTER    (DEAD_ENTER),
        .DEAD_EXIT     (DEAD_EXIT),
        .STABLE_FRAMES (STABLE_FRAMES)
    ) u_y_axis (
        .clk       (clk),
        .rst_n     (rst_n),
        .pos_vld   (frame_q_vld),
        .pos       (y_pos),
        .cls       (y_cls),
        .pulse_pos (y_pulse_pos),
        .pulse_neg (y_pulse_neg)
    );

    always_comb begin
        dir_state            = '0;
        dir_state[DIR_UP]    = (y_cls == CLS_POS);
        dir_state[DIR_DOWN]  = (y_cls == CLS_NEG);
        dir_state[DIR_LEFT]  = (x_cls == CLS_NEG);
        dir_state[DIR_RIGHT] = (x_cls == CLS_POS);
        dir_pulse            = '0;
        dir_pulse[DIR_UP]    = y_pulse_pos;
        dir_pulse[DIR_DOWN]  = y_pulse_neg;
        dir_pulse[DIR_LEFT]  = x_pulse_neg;
        dir_pulse[DIR_RIGHT] = x_pulse_pos;
    end

endmodule
